// File: rtl/fpu_issue_ctrl.sv
// FP issue sequencer and register scoreboard between decode and the
// multi-cycle FPU. Tracks pending FP register writes, stalls decode on
// RAW/WAW hazards or a busy FPU, runs the FPU req/gnt/done handshake,
// shares the single FP regfile write port with returning loads, and
// accumulates the FP exception flags.
module fpu_issue_ctrl #(
  parameter int NFREG  = 8,
  parameter int FLAG_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dec_valid,
  input  logic [6:0]        fpu_op,
  input  logic [2:0]        f_rd,
  input  logic [2:0]        f_rs1,
  input  logic [2:0]        f_rs2,
  input  logic [2:0]        f_frm,
  input  logic              F_LW,
  input  logic              F_SW,
  input  logic              flush,
  output logic              fpu_stall,
  output logic              fpu_req,
  input  logic              fpu_gnt,
  output logic [6:0]        fpu_op_o,
  output logic [2:0]        fpu_frm_o,
  output logic [2:0]        fpu_rs1_o,
  output logic [2:0]        fpu_rs2_o,
  input  logic              fpu_done,
  input  logic [FLAG_W-1:0] fpu_flags,
  input  logic              ld_done,
  output logic              freg_wen,
  output logic [2:0]        freg_waddr,
  output logic              freg_wsel,
  input  logic              fflags_clr,
  output logic [FLAG_W-1:0] fflags,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NFREG-1:0]  pend_q, pend_d;
  logic              ld_pend_q, ld_pend_d;
  logic [2:0]        ld_rd_q, ld_rd_d;
  logic [2:0]        rd_q, rd_d;
  logic [6:0]        op_q, op_d;
  logic [2:0]        frm_q, frm_d;
  logic [2:0]        rs1_q, rs1_d;
  logic [2:0]        rs2_q, rs2_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] fflags_q, fflags_d;

  logic is_arith, hazard, accept, acc_ar, acc_ld;
  logic ld_wr, wb_wr, iss_kill;

  assign is_arith = !F_LW && !F_SW;

  // Hazard check reads registered pending bits only: a register being
  // written this cycle still stalls its consumer this cycle.
  always_comb begin
    hazard = 1'b0;
    if (F_LW)      hazard = pend_q[f_rd] | ld_pend_q;
    else if (F_SW) hazard = pend_q[f_rs2];
    else           hazard = pend_q[f_rs1] | pend_q[f_rs2] | pend_q[f_rd];
  end

  assign accept    = dec_valid && !flush && !hazard && (!is_arith || state_q == S_IDLE);
  assign acc_ar    = accept && is_arith;
  assign acc_ld    = accept && F_LW;
  assign fpu_stall = dec_valid && !flush && !accept;

  // A load return only counts when a load is actually outstanding, so a
  // stray ld_done after reset is dropped. Loads always own the write port.
  assign ld_wr    = ld_done && ld_pend_q;
  assign wb_wr    = (state_q == S_WB) && !ld_wr;
  assign iss_kill = (state_q == S_ISSUE) && !fpu_gnt && flush;

  // FSM next state: grant beats flush in ISSUE, flush has no effect once granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc_ar)        state_d = S_ISSUE;
      S_ISSUE: if (fpu_gnt)       state_d = S_WAIT;
               else if (flush)    state_d = S_IDLE;
      S_WAIT:  if (fpu_done)      state_d = S_WB;
      S_WB:    if (!ld_wr)        state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Latched operation fields; only loaded from IDLE so they hold through ISSUE.
  always_comb begin
    op_d    = op_q;
    frm_d   = frm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    flags_d = flags_q;
    if (acc_ar) begin
      op_d  = fpu_op;
      frm_d = f_frm;
      rs1_d = f_rs1;
      rs2_d = f_rs2;
      rd_d  = f_rd;
    end
    if (state_q == S_WAIT && fpu_done) flags_d = fpu_flags;
  end

  // Scoreboard and load tracking: clears first, then sets from this cycle's accept.
  always_comb begin
    pend_d    = pend_q;
    ld_pend_d = ld_pend_q;
    ld_rd_d   = ld_rd_q;
    if (ld_wr) begin
      pend_d[ld_rd_q] = 1'b0;
      ld_pend_d       = 1'b0;
    end
    if (wb_wr || iss_kill) pend_d[rd_q] = 1'b0;
    if (acc_ar) pend_d[f_rd] = 1'b1;
    if (acc_ld) begin
      pend_d[f_rd] = 1'b1;
      ld_pend_d    = 1'b1;
      ld_rd_d      = f_rd;
    end
  end

  // Accrued flags: a clear coinciding with a writeback leaves only the new flags.
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr) fflags_d = '0;
    if (wb_wr)      fflags_d = fflags_d | flags_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      ld_pend_q <= 1'b0;
      ld_rd_q   <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      frm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      flags_q   <= '0;
      fflags_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ld_pend_q <= ld_pend_d;
      ld_rd_q   <= ld_rd_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      frm_q     <= frm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      flags_q   <= flags_d;
      fflags_q  <= fflags_d;
    end
  end

  assign fpu_req    = (state_q == S_ISSUE);
  assign fpu_op_o   = op_q;
  assign fpu_frm_o  = frm_q;
  assign fpu_rs1_o  = rs1_q;
  assign fpu_rs2_o  = rs2_q;
  assign freg_wen   = ld_wr || wb_wr;
  assign freg_waddr = ld_wr ? ld_rd_q : rd_q;
  assign freg_wsel  = ld_wr;
  assign fflags     = fflags_q;
  assign busy       = (state_q != S_IDLE) || ld_pend_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a directed cycle table covering the
// single-op, RAW, write-port collision, flush, flag and reset scenarios,
// then random traffic checked against a transaction-level model.
module tb_fpu_issue_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       dec_valid, F_LW, F_SW, flush;
  logic [6:0] fpu_op;
  logic [2:0] f_rd, f_rs1, f_rs2, f_frm;
  logic       fpu_stall, fpu_req, fpu_gnt, fpu_done, ld_done;
  logic [6:0] fpu_op_o;
  logic [2:0] fpu_frm_o, fpu_rs1_o, fpu_rs2_o;
  logic [4:0] fpu_flags, fflags;
  logic       freg_wen, freg_wsel, fflags_clr, busy;
  logic [2:0] freg_waddr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fpu_issue_ctrl dut (
    .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .fpu_op(fpu_op),
    .f_rd(f_rd), .f_rs1(f_rs1), .f_rs2(f_rs2), .f_frm(f_frm),
    .F_LW(F_LW), .F_SW(F_SW), .flush(flush), .fpu_stall(fpu_stall),
    .fpu_req(fpu_req), .fpu_gnt(fpu_gnt), .fpu_op_o(fpu_op_o),
    .fpu_frm_o(fpu_frm_o), .fpu_rs1_o(fpu_rs1_o), .fpu_rs2_o(fpu_rs2_o),
    .fpu_done(fpu_done), .fpu_flags(fpu_flags), .ld_done(ld_done),
    .freg_wen(freg_wen), .freg_waddr(freg_waddr), .freg_wsel(freg_wsel),
    .fflags_clr(fflags_clr), .fflags(fflags), .busy(busy)
  );

  typedef struct {
    bit rst, dv, lw, sw;
    bit [2:0] rd, rs1, rs2;
    bit gnt, done;
    bit [4:0] fl;
    bit ldd, fsh, clr;
    bit e_stall, e_req, e_wen;
    bit [2:0] e_wa;
    bit e_ws;
    bit [4:0] e_ff;
    bit e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t V(input bit rst, dv, lw, sw, input bit [2:0] rd, rs1, rs2,
                             input bit gnt, done, input bit [4:0] fl, input bit ldd, fsh, clr,
                             input bit es, er, ew, input bit [2:0] ewa, input bit ews,
                             input bit [4:0] eff, input bit eb);
    vec_t v;
    v.rst = rst; v.dv = dv; v.lw = lw; v.sw = sw;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.gnt = gnt; v.done = done; v.fl = fl;
    v.ldd = ldd; v.fsh = fsh; v.clr = clr;
    v.e_stall = es; v.e_req = er; v.e_wen = ew;
    v.e_wa = ewa; v.e_ws = ews; v.e_ff = eff; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rst, dv, lw, sw, input bit [2:0] rd, rs1, rs2,
                       input bit gnt, done, input bit [4:0] fl, input bit ldd, fsh, clr);
    RST = rst; dec_valid = dv; F_LW = lw; F_SW = sw;
    f_rd = rd; f_rs1 = rs1; f_rs2 = rs2;
    fpu_gnt = gnt; fpu_done = done; fpu_flags = fl;
    ld_done = ldd; flush = fsh; fflags_clr = clr;
  endtask

  // Observed bundle: {stall, req, wen, waddr, wsel, fflags, busy};
  // waddr/wsel only meaningful on a write.
  function automatic logic [12:0] obs(input bit wen_exp);
    return {fpu_stall, fpu_req, freg_wen, wen_exp ? freg_waddr : 3'd0,
            wen_exp ? freg_wsel : 1'b0, fflags, busy};
  endfunction

  // Reference model state
  bit       m_pend[8];
  bit       job_on, job_gnt, job_fin;
  bit [2:0] job_rd, job_rs1, job_rs2, job_frm;
  bit [6:0] job_op;
  bit [4:0] job_fl, m_ff;
  bit       ld_on;
  bit [2:0] ld_rd;

  // Random stimulus for the current cycle
  bit       r_rst, r_dv, r_lw, r_sw, r_gnt, r_done, r_ldd, r_fsh, r_clr;
  bit [2:0] r_rd, r_rs1, r_rs2;
  bit [4:0] r_fl;

  initial begin
    // Columns: rst dv lw sw rd rs1 rs2 gnt done fl ldd fsh clr | stall req wen wa ws ff busy
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,0)); // post-reset idle
    vt.push_back(V(0,1,0,0, 3,1,2, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,0)); // fadd f3 accepted
    vt.push_back(V(0,0,0,0, 0,0,0, 1,0,5'h00, 0,0,0,  0,1,0,0,0,5'h00,1)); // ISSUE, gnt
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,1));
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,1));
    vt.push_back(V(0,0,0,0, 0,0,0, 0,1,5'h01, 0,0,0,  0,0,0,0,0,5'h00,1)); // done, NX
    vt.push_back(V(0,1,0,0, 5,3,0, 0,0,5'h00, 0,0,0,  1,0,1,3,0,5'h00,1)); // WB f3, dependent stalls
    vt.push_back(V(0,1,0,0, 5,3,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h01,0)); // dependent accepted
    vt.push_back(V(0,0,0,0, 0,0,0, 1,0,5'h00, 0,0,0,  0,1,0,0,0,5'h01,1)); // req two after write
    vt.push_back(V(0,0,0,0, 0,0,0, 0,1,5'h04, 0,0,0,  0,0,0,0,0,5'h01,1));
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,0,1,  0,0,1,5,0,5'h01,1)); // WB f5 with clear
    vt.push_back(V(0,1,1,0, 6,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h04,0)); // flw f6
    vt.push_back(V(0,1,0,0, 2,0,1, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h04,1)); // arith f2
    vt.push_back(V(0,0,0,0, 0,0,0, 1,0,5'h00, 0,0,0,  0,1,0,0,0,5'h04,1));
    vt.push_back(V(0,0,0,0, 0,0,0, 0,1,5'h00, 0,0,0,  0,0,0,0,0,5'h04,1));
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 1,0,0,  0,0,1,6,1,5'h04,1)); // load wins port
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,0,1,2,0,5'h04,1)); // FPU writes next
    vt.push_back(V(0,1,0,0, 7,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h04,0)); // fsub f7
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,1,0,  0,1,0,0,0,5'h04,1)); // flush in ISSUE
    vt.push_back(V(0,1,0,0, 1,7,7, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h04,0)); // f7 no longer pending
    vt.push_back(V(0,0,0,0, 0,0,0, 1,0,5'h00, 0,1,0,  0,1,0,0,0,5'h04,1)); // gnt beats flush
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,1,0,  0,0,0,0,0,5'h04,1)); // flush ignored in WAIT
    vt.push_back(V(0,0,0,0, 0,0,0, 0,1,5'h10, 0,0,0,  0,0,0,0,0,5'h04,1));
    vt.push_back(V(0,1,0,1, 0,0,1, 0,0,5'h00, 0,0,0,  1,0,1,1,0,5'h04,1)); // fsw stalls on f1
    vt.push_back(V(0,1,0,1, 0,0,1, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h14,0)); // fsw accepted
    vt.push_back(V(0,1,0,0, 4,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h14,0));
    vt.push_back(V(1,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,1,0,0,0,5'h14,1)); // reset in ISSUE
    vt.push_back(V(0,1,1,0, 4,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,0)); // f4 cleared by reset
    vt.push_back(V(1,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,1)); // reset with load out
    vt.push_back(V(0,0,0,0, 0,0,0, 0,1,5'h1f, 1,0,0,  0,0,0,0,0,5'h00,0)); // stale done/ld_done
    vt.push_back(V(0,0,0,0, 0,0,0, 0,0,5'h00, 0,0,0,  0,0,0,0,0,5'h00,0));

    fpu_op = 7'h10; f_frm = 3'd1;
    drive(1, 0,0,0, 0,0,0, 0,0,5'h00, 0,0,0);
    repeat (2) @(posedge CLK);

    foreach (vt[i]) begin
      @(negedge CLK);
      drive(vt[i].rst, vt[i].dv, vt[i].lw, vt[i].sw, vt[i].rd, vt[i].rs1, vt[i].rs2,
            vt[i].gnt, vt[i].done, vt[i].fl, vt[i].ldd, vt[i].fsh, vt[i].clr);
      #1;
      chk($sformatf("vec[%0d]", i), 32'(obs(vt[i].e_wen)),
          32'({vt[i].e_stall, vt[i].e_req, vt[i].e_wen, vt[i].e_wa, vt[i].e_ws,
               vt[i].e_ff, vt[i].e_busy}));
    end

    // Directed table ends with everything idle and clear; model starts there.
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    job_on = 0; job_gnt = 0; job_fin = 0; ld_on = 0; m_ff = '0;
    job_rd = '0; job_rs1 = '0; job_rs2 = '0; job_frm = '0; job_op = '0; job_fl = '0; ld_rd = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit arith, hz, acc, ldw, fw, e_stall, e_req, e_busy, e_wen, e_ws;
      bit [2:0] e_wa;
      int ty;
      @(negedge CLK);
      r_rst  = ($urandom_range(0, 199) == 0);
      r_dv   = ($urandom_range(0, 9) < 7);
      ty     = $urandom_range(0, 19);
      r_lw   = (ty >= 12 && ty < 17);
      r_sw   = (ty >= 17);
      r_rd   = 3'($urandom_range(0, 7));
      r_rs1  = 3'($urandom_range(0, 7));
      r_rs2  = 3'($urandom_range(0, 7));
      r_gnt  = ($urandom_range(0, 1) == 1);
      r_done = ($urandom_range(0, 9) < 3);
      r_fl   = 5'($urandom);
      r_ldd  = ($urandom_range(0, 3) == 0);
      r_fsh  = ($urandom_range(0, 11) == 0);
      r_clr  = ($urandom_range(0, 19) == 0);
      fpu_op = 7'($urandom);
      f_frm  = 3'($urandom);
      drive(r_rst, r_dv, r_lw, r_sw, r_rd, r_rs1, r_rs2, r_gnt, r_done, r_fl, r_ldd, r_fsh, r_clr);
      #1;

      arith = !r_lw && !r_sw;
      if (r_lw)      hz = m_pend[r_rd] || ld_on;
      else if (r_sw) hz = m_pend[r_rs2];
      else           hz = m_pend[r_rs1] || m_pend[r_rs2] || m_pend[r_rd];
      acc     = r_dv && !r_fsh && !hz && (!arith || !job_on);
      e_stall = r_dv && !r_fsh && !acc;
      ldw     = r_ldd && ld_on;
      fw      = job_fin && !ldw;
      e_req   = job_on && !job_gnt;
      e_busy  = job_on || ld_on;
      e_wen   = ldw || fw;
      e_wa    = ldw ? ld_rd : job_rd;
      e_ws    = ldw;

      chk($sformatf("rand[%0d]", cyc), 32'(obs(e_wen)),
          32'({e_stall, e_req, e_wen, e_wen ? e_wa : 3'd0, e_wen ? e_ws : 1'b0, m_ff, e_busy}));
      if (e_req)
        chk($sformatf("rand_op[%0d]", cyc), 32'({fpu_op_o, fpu_frm_o, fpu_rs1_o, fpu_rs2_o}),
            32'({job_op, job_frm, job_rs1, job_rs2}));

      @(posedge CLK);
      if (r_rst) begin
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        job_on = 0; job_gnt = 0; job_fin = 0; ld_on = 0; m_ff = '0;
      end else begin
        if (ldw) begin m_pend[ld_rd] = 1'b0; ld_on = 0; end
        if (r_clr) m_ff = '0;
        if (fw) begin
          m_pend[job_rd] = 1'b0; m_ff |= job_fl;
          job_on = 0; job_gnt = 0; job_fin = 0;
        end else if (job_on && !job_gnt) begin
          if (r_gnt) job_gnt = 1;
          else if (r_fsh) begin m_pend[job_rd] = 1'b0; job_on = 0; end
        end else if (job_on && job_gnt && !job_fin && r_done) begin
          job_fin = 1; job_fl = r_fl;
        end
        if (acc && arith) begin
          job_on = 1; job_gnt = 0; job_fin = 0;
          job_rd = r_rd; job_rs1 = r_rs1; job_rs2 = r_rs2;
          job_op = fpu_op; job_frm = f_frm;
          m_pend[r_rd] = 1'b1;
        end
        if (acc && r_lw) begin
          ld_on = 1; ld_rd = r_rd; m_pend[r_rd] = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
